// File: rtl/sorted_digit_divider.sv
// Purpose: sorts NUM_DIGITS excess-3 digits, divides the remaining digits (as a decimal number) by sorted[DIV_IDX], streams quotient MSB-first.
// Latency: last digit edge to first out_valid edge = NUM_DIGITS+Q_W+2 (NUM_DIGITS+2 on zero divisor or invalid digit).
// Backpressure: none; in_valid is ignored while busy outside INPUT. Optional macro REMAINDER_OUT_EN appends the 4-bit remainder.
module sorted_digit_divider #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_IDX    = 1,
    parameter int Q_W        = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       out_valid,
    output logic       out_data,
    output logic       busy,
    output logic       err
);

    function automatic longint pow10(input int e);
        longint r;
        r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    localparam longint MAX_DVD = pow10(NUM_DIGITS - 1) - 1;

    if (NUM_DIGITS < 3 || NUM_DIGITS > 8) begin : g_bad_num_digits
        $error("NUM_DIGITS must be within 3..8");
    end
    if (DIV_IDX < 0 || DIV_IDX >= NUM_DIGITS) begin : g_bad_div_idx
        $error("DIV_IDX must be within 0..NUM_DIGITS-1");
    end
    if ((longint'(1) << Q_W) <= MAX_DVD) begin : g_bad_q_w
        $error("Q_W too narrow for the largest possible dividend");
    end

`ifdef REMAINDER_OUT_EN
    localparam int OUT_W = Q_W + 4;
`else
    localparam int OUT_W = Q_W;
`endif
    localparam int CW = $clog2(Q_W + NUM_DIGITS + 5);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INPUT  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_SORT   = 3'd3;
    localparam logic [2:0] S_SETUP  = 3'd4;
    localparam logic [2:0] S_DIV    = 3'd5;
    localparam logic [2:0] S_OUTPUT = 3'd6;

    logic [2:0]       state;
    logic [3:0]       dig      [NUM_DIGITS];
    logic [3:0]       sorted_n [NUM_DIGITS];
    logic [CW-1:0]    cnt;
    logic             err_q;
    logic [3:0]       dvs;
    logic [3:0]       prem;
    logic [Q_W-1:0]   aq;
    logic [OUT_W-1:0] osr;

    logic             dec_bad;
    logic [Q_W-1:0]   dvd_c;
    logic [4:0]       trial;
    logic             ge;
    logic [3:0]       prem_n;
    logic [Q_W-1:0]   aq_n;
    logic [OUT_W-1:0] osr_ld;

    assign busy = (state != S_IDLE);
    assign err  = err_q;

    // Flag any raw code outside the excess-3 range 3..12.
    always_comb begin
        dec_bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig[i] < 4'd3 || dig[i] > 4'd12) dec_bad = 1'b1;
        end
    end

    // One odd-even transposition step; larger value moves to the lower index, ties stay put.
    always_comb begin
        sorted_n = dig;
        for (int i = 0; i + 1 < NUM_DIGITS; i++) begin
            if (i[0] == cnt[0] && dig[i+1] > dig[i]) begin
                sorted_n[i]   = dig[i+1];
                sorted_n[i+1] = dig[i];
            end
        end
    end

    // Fold the non-divisor digits, most significant first, into a binary dividend.
    always_comb begin
        dvd_c = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i != DIV_IDX) dvd_c = dvd_c * Q_W'(10) + Q_W'(dig[i]);
        end
    end

    // Restoring division step: dividend bits leave aq at the top, quotient bits enter at the bottom.
    always_comb begin
        trial  = {prem, aq[Q_W-1]};
        ge     = (trial >= {1'b0, dvs});
        prem_n = ge ? 4'(trial - {1'b0, dvs}) : trial[3:0];
        aq_n   = {aq[Q_W-2:0], ge};
`ifdef REMAINDER_OUT_EN
        osr_ld = {aq_n, prem_n};
`else
        osr_ld = aq_n;
`endif
    end

    // Job sequencer and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            for (int i = 0; i < NUM_DIGITS; i++) dig[i] <= '0;
            cnt       <= '0;
            err_q     <= 1'b0;
            dvs       <= '0;
            prem      <= '0;
            aq        <= '0;
            osr       <= '0;
            out_valid <= 1'b0;
            out_data  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    err_q <= 1'b0;
                    if (in_valid) begin
                        dig[0] <= in_data;
                        cnt    <= CW'(1);
                        state  <= S_INPUT;
                    end
                end
                S_INPUT: begin
                    if (!in_valid) begin
                        // Short burst: abandon silently.
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        for (int i = 1; i < NUM_DIGITS; i++) begin
                            if (cnt == CW'(i)) dig[i] <= in_data;
                        end
                        if (cnt == CW'(NUM_DIGITS - 1)) begin
                            cnt   <= '0;
                            state <= S_DECODE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_DECODE: begin
                    for (int i = 0; i < NUM_DIGITS; i++) dig[i] <= dig[i] - 4'd3;
                    err_q <= dec_bad;
                    cnt   <= '0;
                    state <= S_SORT;
                end
                S_SORT: begin
                    dig <= sorted_n;
                    if (cnt == CW'(NUM_DIGITS - 1)) begin
                        cnt   <= '0;
                        state <= S_SETUP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_SETUP: begin
                    cnt <= '0;
                    if (dig[DIV_IDX] == 4'd0 || err_q) begin
                        // Unusable job: report all ones without dividing.
                        osr       <= '1;
                        out_valid <= 1'b1;
                        out_data  <= 1'b1;
                        state     <= S_OUTPUT;
                    end else begin
                        dvs   <= dig[DIV_IDX];
                        aq    <= dvd_c;
                        prem  <= '0;
                        state <= S_DIV;
                    end
                end
                S_DIV: begin
                    prem <= prem_n;
                    aq   <= aq_n;
                    if (cnt == CW'(Q_W - 1)) begin
                        cnt       <= '0;
                        osr       <= osr_ld;
                        out_valid <= 1'b1;
                        out_data  <= osr_ld[OUT_W-1];
                        state     <= S_OUTPUT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_OUTPUT: begin
                    if (cnt == CW'(OUT_W - 1)) begin
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        out_data  <= 1'b0;
                        err_q     <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        cnt      <= cnt + CW'(1);
                        osr      <= osr << 1;
                        out_data <= osr[OUT_W-2];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sorted_digit_divider.sv
// Directed bench for sorted_digit_divider: default instance plus a 5-digit, Q_W=14 instance.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
// Expected results are hand-computed quotients (and remainders when REMAINDER_OUT_EN is defined).
module tb_sorted_digit_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       iv4, iv5;
    logic [3:0] id4, id5;
    logic       ov4, od4, bz4, er4;
    logic       ov5, od5, bz5, er5;
    logic       sel;

    wire ov = sel ? ov5 : ov4;
    wire od = sel ? od5 : od4;
    wire bz = sel ? bz5 : bz4;
    wire er = sel ? er5 : er4;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef REMAINDER_OUT_EN
    localparam int RX = 4;
`else
    localparam int RX = 0;
`endif

    sorted_digit_divider dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_data(id4),
        .out_valid(ov4), .out_data(od4), .busy(bz4), .err(er4)
    );

    sorted_digit_divider #(.NUM_DIGITS(5), .DIV_IDX(1), .Q_W(14)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv5), .in_data(id5),
        .out_valid(ov5), .out_data(od5), .busy(bz5), .err(er5)
    );

    function automatic logic [31:0] with_rem(input logic [31:0] q, input logic [3:0] r);
`ifdef REMAINDER_OUT_EN
        return (q << 4) | {28'd0, r};
`else
        return q + {28'd0, r & 4'd0};
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] d);
        if (sel) begin
            iv5 = v; id5 = d;
        end else begin
            iv4 = v; id4 = d;
        end
    endtask

    task automatic send(input logic [31:0] digs, input int nd);
        for (int i = 0; i < nd; i++) begin
            drive(1'b1, digs[4*i +: 4]);
            @(posedge clk); #1;
        end
        drive(1'b0, 4'd0);
    endtask

    task automatic run_job(input string tag, input logic [31:0] digs, input int nd,
                           input int pulse_at, input int exp_lat,
                           input logic [31:0] exp_bits, input int nbits, input logic exp_err);
        int lat;
        int hi;
        logic [31:0] got;
        send(digs, nd);
        chk({tag, "_busy_start"}, {31'd0, bz}, 32'd1);
        lat = -1;
        for (int e = 1; e <= 80; e++) begin
            if (e == pulse_at) drive(1'b1, 4'd5);
            @(posedge clk); #1;
            drive(1'b0, 4'd0);
            if (ov) begin
                lat = e;
                break;
            end
        end
        chk({tag, "_latency"}, lat, exp_lat);
        got = '0;
        hi  = 0;
        for (int k = 0; k < nbits; k++) begin
            got = {got[30:0], od};
            if (ov) hi++;
            if (k == 0) chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
            @(posedge clk); #1;
        end
        chk({tag, "_bits"}, got, exp_bits);
        chk({tag, "_valid_len"}, hi, nbits);
        chk({tag, "_valid_end"}, {31'd0, ov}, 32'd0);
        chk({tag, "_data_idle"}, {31'd0, od}, 32'd0);
        chk({tag, "_busy_end"}, {31'd0, bz}, 32'd0);
    endtask

    initial begin
        int hi;
        rst_n = 1'b0;
        sel   = 1'b0;
        iv4 = 1'b0; id4 = 4'd0;
        iv5 = 1'b0; id5 = 4'd0;
        #12;
        chk("rst_out_valid", {31'd0, ov4}, 32'd0);
        chk("rst_out_data",  {31'd0, od4}, 32'd0);
        chk("rst_busy",      {31'd0, bz4}, 32'd0);
        chk("rst_err",       {31'd0, er4}, 32'd0);
        chk("rst_out_valid5", {31'd0, ov5}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // digits 1,5,3,9 -> 931 / 5 = 186 r 1
        run_job("basic", 32'h0000_C684, 4, 0, 16, with_rem(32'd186, 4'd1), 10 + RX, 1'b0);
        // digits 0,0,0,7 -> divisor 0
        run_job("divzero", 32'h0000_A333, 4, 0, 6, with_rem(32'h3FF, 4'hF), 10 + RX, 1'b0);
        // code 15 is not excess-3
        run_job("baddigit", 32'h0000_C6F4, 4, 0, 6, with_rem(32'h3FF, 4'hF), 10 + RX, 1'b1);

        // five digits 9,8,7,6,5 -> 9765 / 8 = 1220 r 5
        sel = 1'b1;
        run_job("five", 32'h0008_9ABC, 5, 0, 21, with_rem(32'd1220, 4'd5), 14 + RX, 1'b0);
        sel = 1'b0;

        // stray in_valid during DIV, then a new job the cycle after busy falls
        run_job("b2b_first", 32'h0000_C684, 4, 10, 16, with_rem(32'd186, 4'd1), 10 + RX, 1'b0);
        // digits 4,2,8,1 -> 821 / 4 = 205 r 1
        run_job("b2b_second", 32'h0000_4B57, 4, 0, 16, with_rem(32'd205, 4'd1), 10 + RX, 1'b0);

        // burst shorter than NUM_DIGITS is abandoned
        send(32'h0000_0084, 2);
        hi = 0;
        for (int c = 0; c < 40; c++) begin
            if (ov4) hi++;
            @(posedge clk); #1;
        end
        chk("abandon_no_output", hi, 0);
        chk("abandon_idle", {31'd0, bz4}, 32'd0);

        // asynchronous reset in the middle of DIV
        send(32'h0000_C684, 4);
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("midrst_busy_before", {31'd0, bz4}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, ov4}, 32'd0);
        chk("midrst_out_data",  {31'd0, od4}, 32'd0);
        chk("midrst_busy",      {31'd0, bz4}, 32'd0);
        chk("midrst_err",       {31'd0, er4}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        hi = 0;
        for (int c = 0; c < 40; c++) begin
            if (ov4) hi++;
            @(posedge clk); #1;
        end
        chk("midrst_no_output", hi, 0);
        run_job("after_rst", 32'h0000_4B57, 4, 0, 16, with_rem(32'd205, 4'd1), 10 + RX, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sorted_digit_divider.md
Name: sorted_digit_divider

Overview:
- Serial-in/serial-out arithmetic block.
- Accepts NUM_DIGITS excess-3 coded decimal digits, decodes them, and sorts them in descending order.
- Uses the sorted digit at position DIV_IDX as the divisor. The remaining digits, kept in descending order, form a decimal dividend.
- Performs restoring division one quotient bit per cycle, then shifts the quotient out MSB-first.
- This is the parametrised successor of the fixed 4-digit divider. It adds a configurable digit count and divisor position, a busy indication, and invalid-digit detection.

Parameters:
- NUM_DIGITS, 4, number of input digits; legal range 3..8.
- DIV_IDX, 1, index of the divisor in the descending-sorted list; 0 = largest; legal range 0..NUM_DIGITS-1.
- Q_W, 10, dividend/quotient width in bits; must satisfy 2^Q_W > 10^(NUM_DIGITS-1)-1; elaboration error otherwise.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies in_data; high for exactly NUM_DIGITS consecutive cycles per job.
- in_data  input  4  excess-3 digit; first digit first.
- out_valid  output  1  high while out_data carries result bits.
- out_data  output  1  serial result bit, MSB first.
- busy  output  1  high from the first sampled digit until the edge after the last output bit.
- err  output  1  sticky per job; high during output if any input digit was invalid.

Behaviour:
- Reset (async, rst_n low): out_valid=0, out_data=0, busy=0, err=0, FSM to IDLE, all digit/dividend/divisor/counter registers cleared. Reset mid-job aborts the job with no partial output.
- States and transitions:
  - IDLE: on in_valid=1, sample digit 0 and go to INPUT.
  - INPUT: samples the remaining NUM_DIGITS-1 digits. After the edge that samples the last digit, go to DECODE.
  - DECODE (1 cycle): each digit minus 3. A digit is invalid if in_data<3 or in_data>12; any invalid digit sets the err flag.
  - SORT (NUM_DIGITS cycles): odd-even transposition. Even-pair compare/swap on even counts, odd-pair on odd counts, larger value moves to the lower index. Equal values are not swapped.
  - SETUP (1 cycle):
    - divisor = sorted[DIV_IDX].
    - dividend = remaining digits in descending order, read as a decimal number (most significant first), zero-extended to Q_W bits.
    - If divisor==0 or err, skip to OUTPUT with quotient forced to all ones.
  - DIV (Q_W cycles): restoring division. Partial remainder is 5 bits. Each cycle shifts in the dividend MSB, subtracts if ≥ divisor, and shifts the quotient bit in.
  - OUTPUT (Q_W cycles): out_valid=1, out_data = quotient[Q_W-1] down to quotient[0]. Return to IDLE on the last bit.
- out_valid and out_data are registered. out_valid rises on the edge entering OUTPUT.
- Latency, last-digit sampling edge to first out_valid edge:
  - Normal path: NUM_DIGITS+Q_W+2 edges (16 at defaults).
  - Zero divisor or err: NUM_DIGITS+2 edges (6 at defaults).
- out_valid is high for exactly Q_W consecutive cycles (Q_W+4 with the optional feature). out_data=0 whenever out_valid=0.
- in_valid while busy=1 (outside INPUT) is ignored. The next job may start the cycle after busy falls.
- in_valid dropping before NUM_DIGITS digits have been sampled: the job is abandoned, the FSM returns to IDLE, and nothing is output.
- err clears on entering IDLE.

Optional Feature:
- Macro REMAINDER_OUT_EN.
- Defined: after the Q_W quotient bits, out_valid stays high for 4 more cycles. During those cycles out_data shifts out the 4-bit remainder, MSB first. On divide-by-zero or err, the remainder is sent as 4'b1111.
- Undefined: quotient only; remainder is not stored beyond the DIV datapath.

Test Plan:
- Defaults, in_data 4,8,6,12 (digits 1,5,3,9): sorted 9,5,3,1, divisor 5, dividend 931. Expect out_valid 10 cycles, bits 0010111010 (186), first bit 16 edges after last digit. With REMAINDER_OUT_EN, 0001 follows.
- Defaults, in_data 3,3,3,10 (digits 0,0,0,7): divisor 0. Expect 1111111111 starting 6 edges after last digit; err=0.
- Defaults, in_data 4,15,6,12: err=1 during output, output 1111111111.
- NUM_DIGITS=5, Q_W=14, in_data 12,11,10,9,8 (digits 9,8,7,6,5): divisor 8, dividend 9765. Expect 00010011000100 (1220); remainder 0101 if REMAINDER_OUT_EN.
- Back-to-back jobs: in_valid pulsed during DIV is ignored. A second job started the cycle after busy falls produces a correct independent result.
- Async reset asserted mid-DIV: outputs go to 0 immediately, no out_valid afterwards. A following job completes normally.
